// File: rtl/muldiv_sequencer_if.sv
// Core-side bundle for the iterative multiply/divide unit.
// Carries the HI/LO command signals and the unit's status back to the core.
interface muldiv_sequencer_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [1:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            hi_we;
    logic            lo_we;
    logic [XLEN-1:0] wdata;
    logic            read_hilo;
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;
    logic            busy;
    logic            done;
    logic            stall;

    modport master (
        output start, op, a, b,
        output hi_we, lo_we, wdata, read_hilo,
        input  hi, lo, busy, done, stall
    );

    modport slave (
        input  start, op, a, b,
        input  hi_we, lo_we, wdata, read_hilo,
        output hi, lo, busy, done, stall
    );
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO registers.
// One multiplier/quotient bit per clock; sign fix and writeback in FIX.
module muldiv_sequencer #(
    parameter int XLEN = 32
) (
    input  logic                clk,
    input  logic                reset,
    muldiv_sequencer_if.slave   bus
);
    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   dvs_q, dvs_d;
    logic [XLEN-1:0]   aorig_q, aorig_d;
    logic              is_div_q, is_div_d;
    logic              neg_q_q, neg_q_d;
    logic              neg_r_q, neg_r_d;
    logic              dz_q, dz_d;
    logic [XLEN-1:0]   hi_q, hi_d;
    logic [XLEN-1:0]   lo_q, lo_d;
    logic              done_q, done_d;

    logic              sgn;
    logic [XLEN-1:0]   a_mag;
    logic [XLEN-1:0]   b_mag;
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     rem_sh;
    logic [XLEN:0]     div_diff;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo;
    logic [XLEN-1:0]   rem;

    // Operand magnitudes and single-iteration datapath
    assign sgn      = bus.op[0];
    assign a_mag    = (sgn && bus.a[XLEN-1]) ? -bus.a : bus.a;
    assign b_mag    = (sgn && bus.b[XLEN-1]) ? -bus.b : bus.b;
    assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, dvs_q};
    assign rem_sh   = acc_q[2*XLEN-1:XLEN-1];
    assign div_diff = rem_sh - {1'b0, dvs_q};
    assign prod     = neg_q_q ? -acc_q : acc_q;
    assign quo      = neg_q_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    assign rem      = neg_r_q ? -acc_q[2*XLEN-1:XLEN]
                              : acc_q[2*XLEN-1:XLEN];

    // Next-state, iteration and HI/LO write selection
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        dvs_d    = dvs_q;
        aorig_d  = aorig_q;
        is_div_d = is_div_q;
        neg_q_d  = neg_q_q;
        neg_r_d  = neg_r_q;
        dz_d     = dz_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    is_div_d = bus.op[1];
                    neg_q_d  = sgn & (bus.a[XLEN-1] ^ bus.b[XLEN-1]);
                    neg_r_d  = sgn & bus.a[XLEN-1];
                    dz_d     = bus.op[1] && (bus.b == '0);
                    aorig_d  = bus.a;
                    cnt_d    = CW'(XLEN - 1);
                    state_d  = CALC;
                    if (bus.op[1]) begin
                        acc_d = {{XLEN{1'b0}}, a_mag};
                        dvs_d = b_mag;
                    end else begin
                        acc_d = {{XLEN{1'b0}}, b_mag};
                        dvs_d = a_mag;
                    end
                end else begin
                    if (bus.hi_we) hi_d = bus.wdata;
                    if (bus.lo_we) lo_d = bus.wdata;
                end
            end
            CALC: begin
                if (is_div_q) begin
                    if (div_diff[XLEN])
                        acc_d = {rem_sh[XLEN-1:0],
                                 acc_q[XLEN-2:0], 1'b0};
                    else
                        acc_d = {div_diff[XLEN-1:0],
                                 acc_q[XLEN-2:0], 1'b1};
                end else begin
                    if (acc_q[0])
                        acc_d = {mul_sum, acc_q[XLEN-1:1]};
                    else
                        acc_d = {1'b0, acc_q[2*XLEN-1:1]};
                end
                if (cnt_q == '0)
                    state_d = FIX;
                else
                    cnt_d = cnt_q - 1'b1;
            end
            FIX: begin
                done_d  = 1'b1;
                state_d = IDLE;
                if (!is_div_q) begin
                    hi_d = prod[2*XLEN-1:XLEN];
                    lo_d = prod[XLEN-1:0];
                end else if (dz_q) begin
                    hi_d = aorig_q;
                    lo_d = '1;
                end else begin
                    hi_d = rem;
                    lo_d = quo;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any operation
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            dvs_q    <= '0;
            aorig_q  <= '0;
            is_div_q <= 1'b0;
            neg_q_q  <= 1'b0;
            neg_r_q  <= 1'b0;
            dz_q     <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            dvs_q    <= dvs_d;
            aorig_q  <= aorig_d;
            is_div_q <= is_div_d;
            neg_q_q  <= neg_q_d;
            neg_r_q  <= neg_r_d;
            dz_q     <= dz_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;
    assign bus.busy  = (state_q != IDLE);
    assign bus.done  = done_q;
    assign bus.stall = bus.busy & (bus.start | bus.read_hilo |
                                   bus.hi_we | bus.lo_we);

    // The decoder never issues a mult/div and an MTHI/MTLO together
    a_no_start_and_write : assert property (
        @(posedge clk) disable iff (reset)
        !((state_q == IDLE) && bus.start && (bus.hi_we || bus.lo_we))
    );
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: directed vectors push expected
// {hi,lo}; a monitor pops and compares on every done pulse.
module tb_muldiv_sequencer;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    logic [63:0] exp_q[$];

    always #5 clk = ~clk;

    muldiv_sequencer_if #(.XLEN(32)) bus();

    muldiv_sequencer #(.XLEN(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding result
    always @(negedge clk) begin
        if (!reset && bus.done) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL done_unexpected: got %h_%h expected none",
                         bus.hi, bus.lo);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                if ({bus.hi, bus.lo} !== e) begin
                    errors++;
                    $display("FAIL result: got %h_%h expected %h",
                             bus.hi, bus.lo, e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input bit push,
                         input logic [63:0] e);
        if (push) exp_q.push_back(e);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_done(output int lat, output int bc,
                             output int chg);
        logic [63:0] h0;
        h0  = {bus.hi, bus.lo};
        lat = 0;
        bc  = 0;
        chg = 0;
        forever begin
            @(negedge clk);
            lat++;
            if (bus.busy) bc++;
            if (bus.done) break;
            if ({bus.hi, bus.lo} !== h0) chg++;
            if (lat > 60) begin
                checks++;
                errors++;
                $display("FAIL timeout: got no done expected within 60");
                break;
            end
        end
        tick();
    endtask

    task automatic run(input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [63:0] e);
        int lat, bc, chg;
        issue(op, a, b, 1'b1, e);
        wait_done(lat, bc, chg);
        check("latency", 64'(lat), 64'd34);
    endtask

    initial begin
        int lat, bc, chg, dcnt;
        reset         = 1'b1;
        bus.start     = 1'b0;
        bus.op        = 2'b00;
        bus.a         = '0;
        bus.b         = '0;
        bus.hi_we     = 1'b0;
        bus.lo_we     = 1'b0;
        bus.wdata     = '0;
        bus.read_hilo = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("reset_hilo", {bus.hi, bus.lo}, 64'h0);
        check("reset_flags", {61'h0, bus.busy, bus.done, bus.stall}, 64'h0);
        tick();

        // MULTU max*max, with busy window and HI/LO hold
        issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1,
              64'hFFFF_FFFE_0000_0001);
        wait_done(lat, bc, chg);
        check("multu_latency", 64'(lat), 64'd34);
        check("multu_busy_cycles", 64'(bc), 64'd33);
        check("multu_hold", 64'(chg), 64'd0);

        run(2'b01, 32'hFFFF_FFFD, 32'd7, 64'hFFFF_FFFF_FFFF_FFEB);
        run(2'b11, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD);
        run(2'b11, 32'd7, 32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD);
        run(2'b10, 32'd100, 32'd0, 64'h0000_0064_FFFF_FFFF);
        run(2'b11, 32'hFFFF_FFFB, 32'd0, 64'hFFFF_FFFB_FFFF_FFFF);
        run(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000);
        run(2'b01, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
        run(2'b00, 32'h1234_5678, 32'h10, 64'h0000_0001_2345_6780);

        // Stall: read_hilo at cycle 5, second start at cycle 6 (ignored)
        issue(2'b00, 32'd3, 32'd5, 1'b1, 64'd15);
        repeat (4) tick();
        bus.read_hilo = 1'b1;
        @(negedge clk);
        check("stall_read", 64'(bus.stall), 64'd1);
        check("hold_read", {bus.hi, bus.lo}, 64'h0000_0001_2345_6780);
        tick();
        bus.read_hilo = 1'b0;
        bus.start     = 1'b1;
        bus.op        = 2'b10;
        bus.a         = 32'd1;
        bus.b         = 32'd1;
        @(negedge clk);
        check("stall_start", 64'(bus.stall), 64'd1);
        tick();
        bus.start = 1'b0;
        wait_done(lat, bc, chg);
        check("stall_latency", 64'(6 + lat), 64'd34);
        check("stall_hold", 64'(chg), 64'd0);
        @(negedge clk);
        check("second_start_dropped", 64'(bus.busy), 64'd0);
        tick();

        // MTLO in IDLE, then during busy
        bus.lo_we = 1'b1;
        bus.wdata = 32'h1234_5678;
        tick();
        bus.lo_we = 1'b0;
        @(negedge clk);
        check("mtlo_idle", 64'(bus.lo), 64'h1234_5678);
        check("mtlo_hi_kept", 64'(bus.hi), 64'h0);
        tick();
        bus.hi_we = 1'b1;
        bus.wdata = 32'hCAFE_0001;
        tick();
        bus.hi_we = 1'b0;
        issue(2'b00, 32'd2, 32'd3, 1'b1, 64'd6);
        repeat (3) tick();
        bus.lo_we = 1'b1;
        bus.wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        check("stall_mtlo", 64'(bus.stall), 64'd1);
        tick();
        bus.lo_we = 1'b0;
        @(negedge clk);
        check("mtlo_busy_dropped", {bus.hi, bus.lo},
              64'hCAFE_0001_1234_5678);
        wait_done(lat, bc, chg);

        // Reset in the middle of a DIV, then a fresh DIVU
        issue(2'b11, 32'hFFFF_FFF9, 32'd2, 1'b0, 64'h0);
        repeat (9) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("abort_hilo", {bus.hi, bus.lo}, 64'h0);
        check("abort_busy", 64'(bus.busy), 64'd0);
        dcnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done) dcnt++;
        end
        check("abort_no_done", 64'(dcnt), 64'd0);
        tick();
        run(2'b10, 32'd9, 32'd4, 64'h0000_0001_0000_0002);

        repeat (3) tick();
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Iterative multiply/divide unit that owns the HI/LO special registers for the single-cycle MIPS core.
- Executes MULT, MULTU, DIV and DIVU over multiple cycles.
- Services MTHI/MTLO writes and MFHI/MFLO reads.
- Raises a stall to the core whenever an instruction touches HI/LO while an operation is in flight.

Parameters:
- XLEN, 32, operand/result width; iteration count equals XLEN.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous active-high reset
- start  input  1  decoded mult/div instruction is valid this cycle
- op  input  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV
- a  input  XLEN  rs operand (multiplicand / dividend)
- b  input  XLEN  rt operand (multiplier / divisor)
- hi_we  input  1  MTHI write enable
- lo_we  input  1  MTLO write enable
- wdata  input  XLEN  MTHI/MTLO data
- read_hilo  input  1  MFHI/MFLO in decode this cycle
- hi  output  XLEN  HI register
- lo  output  XLEN  LO register
- busy  output  1  operation in flight
- done  output  1  one-cycle pulse when HI/LO take a new result
- stall  output  1  core must hold PC and suppress writes this cycle

Behaviour:
- Reset: synchronous, active-high, highest priority; aborts any operation. Next edge gives state IDLE, hi=0, lo=0, busy=0, done=0, and clears all internal accumulators and the counter.
- States:
  - IDLE: busy=0. start=1 latches op, |a|, |b| (magnitudes only for signed ops), result signs and div-by-zero flag, loads counter=XLEN-1, then goes to CALC.
  - CALC: busy=1. One iteration per clock, counter decrements; at counter==0 goes to FIX.
    - Multiply: shift-add on a 2*XLEN accumulator, one multiplier bit per iteration, LSB first.
    - Divide: restoring; remainder shifts in one dividend bit MSB first, subtracts divisor if no borrow, and shifts a quotient bit into the accumulator.
  - FIX: busy=1. Applies sign correction, writes hi/lo, sets done=1 for exactly the next cycle, then goes to IDLE.
- Latency:
  - start sampled at edge 0; iterations occur on edges 1..32; FIX writes hi/lo at edge 33.
  - done is high in the cycle after edge 33; busy is high in the cycles after edges 0..32 (33 cycles).
  - A new start is accepted in the same cycle done is high.
- Results:
  - MULT/MULTU: {hi,lo} = 64-bit product. Signed: negate the 64-bit magnitude product if a[31]^b[31].
  - DIV/DIVU: lo = quotient, hi = remainder.
  - Signed divide: quotient negated if a[31]^b[31]; remainder takes the sign of a (truncating division).
- Boundary cases:
  - Divide by zero (b==0, either signedness): run full latency, then hi=a (original value), lo=0xFFFFFFFF; no sign fix.
  - DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0 (wraps naturally through magnitude arithmetic).
  - MULT 0x80000000*0x80000000: hi=0x40000000, lo=0.
- Handshake and stall:
  - stall = busy & (start | read_hilo | hi_we | lo_we). The core holds the instruction until stall drops.
  - start while busy is ignored; the in-flight operation is not disturbed.
- MTHI/MTLO:
  - When not busy, hi_we/lo_we write wdata to hi/lo at the clock edge.
  - Writes while busy are ignored (the core is stalled).
  - start and hi_we/lo_we asserted together in IDLE: start wins and the write is dropped. The decoder never issues both together; an assertion flags it.
- Outputs hi/lo change only at reset, FIX, or MTHI/MTLO; they hold their previous values throughout CALC.

Test Plan:
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> done at cycle 34; hi=0xFFFFFFFE, lo=0x00000001; busy high for 33 cycles.
- MULT a=0xFFFFFFFD(-3), b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB (-21); DIV a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU a=100, b=0 -> hi=100, lo=0xFFFFFFFF after full latency; DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- Start MULTU, then at cycle 5 assert read_hilo and a second start -> stall=1 both cycles, second start ignored, hi/lo unchanged until cycle 34.
- MTLO wdata=0x12345678 in IDLE -> lo=0x12345678 next cycle; same write during busy -> lo retains the in-flight result.
- Assert reset at cycle 10 of a DIV -> next cycle busy=0, hi=lo=0, done never pulses; a fresh DIVU 9/4 afterwards -> lo=2, hi=1.
